soc_bus_mst: RTL

//  Single-outstanding initiator for the soc_if CSR bus: takes {we,addr,wdat} commands on a

---
 rtl/soc_pkg.sv | 20 ++
 rtl/soc_bus_mst_tmo.sv | 26 ++
 rtl/soc_bus_mst.sv | 137 +++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared types and constants for the soc_if CSR bus initiator.
package soc_pkg;

  localparam int          SOC_BUS_AW       = 32;
  localparam logic [31:0] SOC_BUS_ERR_RDAT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [3:0]            we;
    logic [SOC_BUS_AW-1:0] addr;
    logic [31:0]           wdat;
  } soc_bus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RSP    = 2'd3
  } soc_bus_mst_state_t;

endpackage

// File: rtl/soc_bus_mst_tmo.sv
// Wait-for-rdy timeout counter; expired is high on the TIMEOUT_CYC-th waiting cycle.
module soc_bus_mst_tmo #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/soc_bus_mst.sv
// Single-outstanding soc_if initiator: command stream in, one bus transfer, response stream out.
// Optional wait-for-rdy timeout enabled by defining SOC_BUS_MST_TIMEOUT_EN.
module soc_bus_mst
  import soc_pkg::*;
#(
  parameter int AW          = 32,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic [3:0]    cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdat,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [31:0]   rsp_rdat,
  output logic          rsp_wr,
  output logic          rsp_err,
  output logic          bus_vld,
  input  logic          bus_rdy,
  output logic [3:0]    bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdat,
  input  logic [31:0]   bus_rdat
);

  localparam int         LAT_LAST_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic [1:0] LAT_LAST   = 2'(LAT_LAST_I);

  soc_bus_mst_state_t state_q;
  soc_bus_cmd_t       cmd_q;
  logic [1:0]         lat_cnt_q;
  logic [31:0]        rdat_q;
  logic               wr_q;
  logic               err_q;
  logic               cmd_acc;
  logic               tmo_hit;

  // Handshake-visible outputs decode straight from registered state, so none
  // of them depends combinationally on cmd_vld, bus_rdy or rsp_rdy.
  assign cmd_rdy  = (state_q == ST_IDLE);
  assign bus_vld  = (state_q == ST_REQ);
  assign rsp_vld  = (state_q == ST_RSP);
  assign cmd_acc  = cmd_vld & cmd_rdy;
  assign bus_we   = cmd_q.we;
  assign bus_addr = AW'(cmd_q.addr);
  assign bus_wdat = cmd_q.wdat;
  assign rsp_rdat = rdat_q;
  assign rsp_wr   = wr_q;
  assign rsp_err  = err_q;

`ifdef SOC_BUS_MST_TIMEOUT_EN
  logic tmo_expired;

  soc_bus_mst_tmo #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (cmd_acc),
    .inc     (bus_vld & ~bus_rdy),
    .expired (tmo_expired)
  );

  assign tmo_hit = bus_vld & ~bus_rdy & tmo_expired;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: command/response registers are reset too, because they drive
      // bus_* and rsp_* directly and those outputs must read 0 out of reset.
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      lat_cnt_q <= '0;
      rdat_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge value of state_q/cmd_q regardless of statement order.
      case (state_q)
        ST_IDLE: begin
          if (cmd_vld) begin
            cmd_q.we   <= cmd_we;
            cmd_q.addr <= SOC_BUS_AW'(cmd_addr & {{(AW-2){1'b1}}, 2'b00});
            cmd_q.wdat <= cmd_wdat;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_rdy) begin
            lat_cnt_q <= '0;
            if (cmd_q.we != 4'b0000) begin
              rdat_q  <= '0;
              wr_q    <= 1'b1;
              err_q   <= 1'b0;
              state_q <= ST_RSP;
            end else if (RD_LAT == 0) begin
              rdat_q  <= bus_rdat;
              wr_q    <= 1'b0;
              err_q   <= 1'b0;
              state_q <= ST_RSP;
            end else begin
              state_q <= ST_RDWAIT;
            end
          end else if (tmo_hit) begin
            rdat_q  <= SOC_BUS_ERR_RDAT;
            wr_q    <= (cmd_q.we != 4'b0000);
            err_q   <= 1'b1;
            state_q <= ST_RSP;
          end
        end
        ST_RDWAIT: begin
          // First RDWAIT cycle is one cycle after the handshake.
          if (lat_cnt_q == LAT_LAST) begin
            rdat_q  <= bus_rdat;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_RSP;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        ST_RSP: begin
          if (rsp_rdy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
